// File: rtl/ysyx_22050612_dmem_responder.sv
// Clocked data-memory responder: one request at a time,
// fixed-latency word access, full 64-bit word returned.
module ysyx_22050612_dmem_responder #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [63:0]   a_addr;
  logic [63:0]   a_wdata;
  logic [7:0]    a_wmask;
  logic          a_wen;

  logic [63:0]   mem [DEPTH];

  logic [63:0]   off;
  logic          hit;
  logic [IW-1:0] idx;
  logic [63:0]   merged;
  logic          fire;
  logic          unused_ok;

  assign off = a_addr - BASE;
  assign hit = (a_addr >= BASE) && (off[63:3] < 61'(DEPTH));
  assign idx = off[IW+2:3];

  assign unused_ok = &{1'b0, off[2:0]};

  // Byte merge over the current word; a load leaves it untouched.
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 8; i++) begin
      if (a_wen && a_wmask[i]) begin
        merged[8*i +: 8] = a_wdata[8*i +: 8];
      end
    end
  end

  assign fire       = (state == WAIT) && (cnt == 4'd0);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      a_addr     <= 64'd0;
      a_wdata    <= 64'd0;
      a_wmask    <= 8'd0;
      a_wen      <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
            a_wmask <= req_wmask;
            a_wen   <= req_wen;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_rdata <= hit ? merged : 64'd0;
            resp_err   <= !hit;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never reset; writes only on the access edge.
  always_ff @(posedge clk) begin
    if (fire && a_wen && hit) begin
      mem[idx] <= merged;
    end
  end

endmodule
